// File: rtl/neuron_mac_pkg.sv
// Shared state encoding, width helpers and saturation limits for neuron_mac_pipe.
package neuron_mac_pkg;

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_DRAIN = 2'd1,
      ST_BIAS  = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   localparam int LIMIT_W = 128;

   function automatic int prod_width(input int pix_w, input int w_w);
      return pix_w + w_w + 1;
   endfunction

   function automatic int tree_width(input int pix_w, input int w_w, input int n_ch);
      return prod_width(pix_w, w_w) + $clog2(n_ch);
   endfunction

   // Limits are returned wide; callers truncate to their own width.
   function automatic logic [LIMIT_W-1:0] smax_f(input int width);
      return ({{(LIMIT_W-1){1'b0}}, 1'b1} << (width - 1)) - {{(LIMIT_W-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [LIMIT_W-1:0] smin_f(input int width);
      return {{(LIMIT_W-1){1'b0}}, 1'b1} << (width - 1);
   endfunction

endpackage

// File: rtl/neuron_mac_lane.sv
// One channel of the MAC: unsigned pixel times signed weight, registered as the P1 stage.
module neuron_mac_lane
   import neuron_mac_pkg::*;
#(
   parameter int PIX_W = 8,
   parameter int W_W   = 5,
   localparam int P_W  = prod_width(PIX_W, W_W)
)(
   input  logic             clock,
   input  logic             reset,
   input  logic [PIX_W-1:0] x,
   input  logic [W_W-1:0]   w,
   output logic [P_W-1:0]   prod
);

   logic signed [P_W-1:0] x_ext_s;
   logic signed [P_W-1:0] w_ext_s;
   logic signed [P_W-1:0] prod_s;

   // The pixel gets a zero sign bit so the multiply can be fully signed.
   assign x_ext_s = P_W'($signed({1'b0, x}));
   assign w_ext_s = P_W'($signed(w));
   assign prod_s  = x_ext_s * w_ext_s;

   // P1 product register.
   always_ff @(posedge clock) begin
      if (reset) begin
         prod <= '0;
      end else begin
         prod <= prod_s;
      end
   end

endmodule

// File: rtl/neuron_mac_pipe.sv
// neuron_mac_pipe: N_CH-channel pixel x weight MAC over a frame, plus bias and cat decision.
// Define NEURON_MAC_SAT_EN for saturating accumulate/bias arithmetic and the sat output.
module neuron_mac_pipe
   import neuron_mac_pkg::*;
#(
   parameter int N_CH  = 3,
   parameter int PIX_W = 8,
   parameter int W_W   = 5,
   parameter int B_W   = 24,
   parameter int ACC_W = 40
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_last,
   input  logic [N_CH*PIX_W-1:0] x,
   input  logic [N_CH*W_W-1:0]   w,
   input  logic [B_W-1:0]        b,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic                  out,
   output logic [ACC_W-1:0]      score
`ifdef NEURON_MAC_SAT_EN
   ,
   output logic                  sat
`endif
);

   localparam int P_W = prod_width(PIX_W, W_W);
   localparam int T_W = tree_width(PIX_W, W_W, N_CH);

   state_t                  state_r;
   state_t                  state_next_s;
   logic                    accept_s;
   logic                    release_s;
   logic [N_CH*PIX_W-1:0]   x_r;
   logic [N_CH*W_W-1:0]     w_r;
   logic                    s0_valid_r;
   logic                    s0_last_r;
   logic                    p1_valid_r;
   logic                    p1_last_r;
   logic                    p2_valid_r;
   logic                    p2_last_r;
   logic [P_W-1:0]          prod_a [N_CH];
   logic signed [T_W-1:0]   tree_s;
   logic [ACC_W-1:0]        sum_r;
   logic [ACC_W-1:0]        acc_r;
   logic [B_W-1:0]          bias_r;
   logic [ACC_W-1:0]        bias_ext_s;

   assign accept_s   = in_valid && in_ready;
   assign release_s  = (state_r == ST_HOLD) && res_ready;
   assign bias_ext_s = ACC_W'($signed(bias_r));

   for (genvar k = 0; k < N_CH; k++) begin : g_lane
      neuron_mac_lane #(
         .PIX_W (PIX_W),
         .W_W   (W_W)
      ) u_lane (
         .clock (clock),
         .reset (reset),
         .x     (x_r[k*PIX_W +: PIX_W]),
         .w     (w_r[k*W_W +: W_W]),
         .prod  (prod_a[k])
      );
   end

   // Adder tree over the registered lane products.
   always_comb begin
      tree_s = '0;
      for (int k = 0; k < N_CH; k++) begin
         tree_s = tree_s + T_W'($signed(prod_a[k]));
      end
   end

`ifdef NEURON_MAC_SAT_EN
   localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(smax_f(ACC_W));
   localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(smin_f(ACC_W));

   logic [ACC_W:0] acc_sum_s;
   logic [ACC_W:0] bias_sum_s;
   logic           sat_flag_r;

   // Returns {overflowed, clamped sum}; overflow shows as disagreeing top two bits.
   function automatic logic [ACC_W:0] sat_add_f(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] c);
      logic [ACC_W:0] ext_v;
      ext_v = {a[ACC_W-1], a} + {c[ACC_W-1], c};
      if (ext_v[ACC_W] != ext_v[ACC_W-1]) begin
         return {1'b1, (ext_v[ACC_W] ? ACC_MIN : ACC_MAX)};
      end else begin
         return {1'b0, ext_v[ACC_W-1:0]};
      end
   endfunction

   assign acc_sum_s  = sat_add_f(acc_r, sum_r);
   assign bias_sum_s = sat_add_f(acc_r, bias_ext_s);

   // Sticky saturation flag for the frame, published with the result.
   always_ff @(posedge clock) begin
      if (reset) begin
         sat_flag_r <= 1'b0;
         sat        <= 1'b0;
      end else if (release_s) begin
         sat_flag_r <= 1'b0;
         sat        <= 1'b0;
      end else begin
         if (p2_valid_r && acc_sum_s[ACC_W]) begin
            sat_flag_r <= 1'b1;
         end
         if (state_r == ST_BIAS) begin
            sat <= sat_flag_r | bias_sum_s[ACC_W];
         end
      end
   end
`else
   logic [ACC_W-1:0] acc_sum_s;
   logic [ACC_W-1:0] bias_sum_s;

   assign acc_sum_s  = acc_r + sum_r;
   assign bias_sum_s = acc_r + bias_ext_s;
`endif

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_ACCUM;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state decode; DRAIN leaves on the same edge the last sum lands in acc.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_ACCUM: begin
            if (accept_s && in_last) begin
               state_next_s = ST_DRAIN;
            end else begin
               state_next_s = ST_ACCUM;
            end
         end
         ST_DRAIN: begin
            if (p2_valid_r && p2_last_r) begin
               state_next_s = ST_BIAS;
            end else begin
               state_next_s = ST_DRAIN;
            end
         end
         ST_BIAS: begin
            state_next_s = ST_HOLD;
         end
         ST_HOLD: begin
            if (res_ready) begin
               state_next_s = ST_ACCUM;
            end else begin
               state_next_s = ST_HOLD;
            end
         end
         default: begin
            state_next_s = ST_ACCUM;
         end
      endcase
   end

   // in_ready is registered from the next state so it is glitch-free.
   always_ff @(posedge clock) begin
      if (reset) begin
         in_ready <= 1'b1;
      end else begin
         in_ready <= (state_next_s == ST_ACCUM);
      end
   end

   // Beat capture, then the valid/last shadow of the P1 and P2 stages; never stalls.
   always_ff @(posedge clock) begin
      if (reset) begin
         x_r        <= '0;
         w_r        <= '0;
         s0_valid_r <= 1'b0;
         s0_last_r  <= 1'b0;
         p1_valid_r <= 1'b0;
         p1_last_r  <= 1'b0;
         p2_valid_r <= 1'b0;
         p2_last_r  <= 1'b0;
         sum_r      <= '0;
      end else begin
         if (accept_s) begin
            x_r <= x;
            w_r <= w;
         end
         s0_valid_r <= accept_s;
         s0_last_r  <= accept_s && in_last;
         p1_valid_r <= s0_valid_r;
         p1_last_r  <= s0_last_r;
         p2_valid_r <= p1_valid_r;
         p2_last_r  <= p1_last_r;
         sum_r      <= ACC_W'(tree_s);
      end
   end

   // Accumulator, bias latch and result registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         acc_r     <= '0;
         bias_r    <= '0;
         res_valid <= 1'b0;
         out       <= 1'b0;
         score     <= '0;
      end else begin
         if (release_s) begin
            acc_r <= '0;
         end else if (p2_valid_r) begin
            acc_r <= acc_sum_s[ACC_W-1:0];
         end
         if ((state_r == ST_ACCUM) && accept_s && in_last) begin
            bias_r <= b;
         end
         if (state_r == ST_BIAS) begin
            score     <= bias_sum_s[ACC_W-1:0];
            out       <= ~bias_sum_s[ACC_W-1];
            res_valid <= 1'b1;
         end else if (release_s) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_neuron_mac_pipe.sv
// Self-checking bench for neuron_mac_pipe: a 40-bit and a 16-bit instance see identical
// stimulus and are checked against a per-beat arithmetic reference model.
module tb_neuron_mac_pipe;

   localparam int N_CH  = 3;
   localparam int PIX_W = 8;
   localparam int W_W   = 5;
   localparam int B_W   = 24;
   localparam int ACC_W = 40;
   localparam int ACC_S = 16;
   localparam int X_W   = N_CH * PIX_W;
   localparam int WV_W  = N_CH * W_W;
`ifdef NEURON_MAC_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic             clock = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_last;
   logic [X_W-1:0]   x;
   logic [WV_W-1:0]  w;
   logic [B_W-1:0]   b;
   logic             res_ready;
   logic             in_ready,  in_ready16;
   logic             res_valid, res_valid16;
   logic             out,       out16;
   logic [ACC_W-1:0] score;
   logic [ACC_S-1:0] score16;
`ifdef NEURON_MAC_SAT_EN
   logic             sat, sat16;
`endif

   int     checks = 0;
   int     errors = 0;
   longint beat_q[$];
   longint frame_bias = 0;

   always #5 clock = ~clock;

   neuron_mac_pipe #(.N_CH(N_CH), .PIX_W(PIX_W), .W_W(W_W), .B_W(B_W), .ACC_W(ACC_W)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .x(x), .w(w), .b(b), .res_valid(res_valid), .res_ready(res_ready), .out(out), .score(score)
`ifdef NEURON_MAC_SAT_EN
      , .sat(sat)
`endif
   );

   neuron_mac_pipe #(.N_CH(N_CH), .PIX_W(PIX_W), .W_W(W_W), .B_W(B_W), .ACC_W(ACC_S)) dut16 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready16), .in_last(in_last),
      .x(x), .w(w), .b(b), .res_valid(res_valid16), .res_ready(res_ready), .out(out16), .score(score16)
`ifdef NEURON_MAC_SAT_EN
      , .sat(sat16)
`endif
   );

   // Fit an exact value into a signed width: clamp when saturating, else wrap.
   function automatic longint fit(input longint v, input int width);
      longint hi, lo, m;
      hi = (longint'(1) <<< (width - 1)) - 1;
      lo = -(longint'(1) <<< (width - 1));
      if (SAT) begin
         if (v > hi) return hi;
         if (v < lo) return lo;
         return v;
      end
      m = v & ((longint'(1) <<< width) - 1);
      if (m > hi) m = m - (longint'(1) <<< width);
      return m;
   endfunction

   function automatic longint beat_sum(input logic [X_W-1:0] xv, input logic [WV_W-1:0] wv);
      longint s;
      logic [PIX_W-1:0]      xp;
      logic signed [W_W-1:0] wk;
      s = 0;
      for (int k = 0; k < N_CH; k++) begin
         xp = xv[k*PIX_W +: PIX_W];
         wk = wv[k*W_W +: W_W];
         s = s + longint'(xp) * longint'(wk);
      end
      return s;
   endfunction

   function automatic longint model_score(input int width);
      longint a;
      a = 0;
      foreach (beat_q[i]) a = fit(a + beat_q[i], width);
      return fit(a + frame_bias, width);
   endfunction

   function automatic bit model_sat(input int width);
      longint a;
      bit s;
      a = 0;
      s = 1'b0;
      foreach (beat_q[i]) begin
         if (fit(a + beat_q[i], width) != a + beat_q[i]) s = 1'b1;
         a = fit(a + beat_q[i], width);
      end
      if (fit(a + frame_bias, width) != a + frame_bias) s = 1'b1;
      return s;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_beat(input logic [X_W-1:0] xv, input logic [WV_W-1:0] wv,
                            input logic lst, input logic [B_W-1:0] bv);
      chk("in_ready_before_beat", 64'(in_ready), 64'd1);
      x = xv; w = wv; in_last = lst; b = bv; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      beat_q.push_back(beat_sum(xv, wv));
      if (lst) frame_bias = longint'($signed(bv));
   endtask

   task automatic check_result();
      longint e40, e16;
      e40 = model_score(ACC_W);
      e16 = model_score(ACC_S);
      chk("score",       64'($signed(score)),   e40);
      chk("out",         64'(out),              64'(e40 >= 0));
      chk("score16",     64'($signed(score16)), e16);
      chk("out16",       64'(out16),            64'(e16 >= 0));
      chk("res_valid16", 64'(res_valid16),      64'd1);
      chk("in_ready16",  64'(in_ready16),       64'd0);
`ifdef NEURON_MAC_SAT_EN
      chk("sat",   64'(sat),   64'(model_sat(ACC_W)));
      chk("sat16", 64'(sat16), 64'(model_sat(ACC_S)));
`endif
   endtask

   // Last beat was just accepted; result must appear exactly four edges later.
   task automatic finish_frame(input bit junk);
      for (int c = 1; c <= 4; c++) begin
         if (junk) begin
            x = X_W'($urandom); w = WV_W'($urandom); in_last = 1'($urandom); in_valid = 1'b1;
         end
         tick();
         if (c < 4) begin
            chk("res_valid_early", 64'(res_valid), 64'd0);
            chk("in_ready_drain",  64'(in_ready),  64'd0);
         end else begin
            chk("res_valid_latency", 64'(res_valid), 64'd1);
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      check_result();
   endtask

   task automatic release_result();
      logic [ACC_W-1:0] held;
      held = score;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("res_valid_cleared", 64'(res_valid), 64'd0);
      chk("in_ready_after",    64'(in_ready),  64'd1);
      chk("score_kept",        64'(score),     64'(held));
      beat_q.delete();
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      beat_q.delete();
   endtask

   function automatic logic [B_W-1:0] rand_bias();
      logic [15:0] r;
      r = 16'($urandom);
      return B_W'($signed(r));
   endfunction

   initial begin
      logic [ACC_W-1:0] held;
      int len;
      reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; res_ready = 1'b0;
      x = '0; w = '0; b = '0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_out",       64'(out),       64'd0);
      chk("rst_score",     64'(score),     64'd0);
      chk("rst_score16",   64'(score16),   64'd0);

      // Directed single-beat frame: 30*3 + 20*2 + 10*1 = 140.
      send_beat({8'd10, 8'd20, 8'd30}, {5'd1, 5'd2, 5'd3}, 1'b1, 24'd0);
      finish_frame(1'b0);
      chk("t1_score_140", 64'($signed(score)), 64'd140);
      release_result();

      // Negative weights: 3 beats of 3*255*(-16), bias 100 -> -36620.
      for (int i = 0; i < 3; i++) send_beat({3{8'd255}}, {3{5'b10000}}, (i == 2), 24'd100);
      finish_frame(1'b0);
      chk("t2_score_neg", 64'($signed(score)), -64'sd36620);
      chk("t2_out_neg",   64'(out),            64'd0);
      release_result();

      // Backpressure: result held stable while res_ready stays low, input ignored.
      send_beat(X_W'($urandom), WV_W'($urandom), 1'b0, 24'd0);
      send_beat(X_W'($urandom), WV_W'($urandom), 1'b1, rand_bias());
      finish_frame(1'b0);
      held = score;
      for (int c = 0; c < 10; c++) begin
         x = X_W'($urandom); w = WV_W'($urandom); in_last = 1'($urandom); in_valid = 1'b1;
         tick();
         chk("bp_res_valid", 64'(res_valid), 64'd1);
         chk("bp_score",     64'(score),     64'(held));
         chk("bp_in_ready",  64'(in_ready),  64'd0);
      end
      in_valid = 1'b0; in_last = 1'b0;
      check_result();
      release_result();

      // Next frame starts from a cleared accumulator; 5 beats with bubbles, junk in DRAIN.
      for (int i = 0; i < 5; i++) begin
         send_beat(X_W'($urandom), WV_W'($urandom), (i == 4), rand_bias());
         if (i < 4) tick();
      end
      finish_frame(1'b1);
      release_result();

      // Reset while draining: no result, next frame unaffected.
      for (int i = 0; i < 3; i++) send_beat(X_W'($urandom), WV_W'($urandom), (i == 2), rand_bias());
      tick();
      pulse_reset();
      for (int c = 0; c < 6; c++) begin
         tick();
         chk("drain_rst_res_valid",   64'(res_valid),   64'd0);
         chk("drain_rst_res_valid16", 64'(res_valid16), 64'd0);
      end
      chk("drain_rst_in_ready", 64'(in_ready), 64'd1);
      send_beat(X_W'($urandom), WV_W'($urandom), 1'b0, 24'd0);
      send_beat(X_W'($urandom), WV_W'($urandom), 1'b1, rand_bias());
      finish_frame(1'b0);
      release_result();

      // Reset while holding a result.
      send_beat(X_W'($urandom), WV_W'($urandom), 1'b1, rand_bias());
      finish_frame(1'b0);
      pulse_reset();
      chk("hold_rst_res_valid", 64'(res_valid), 64'd0);
      chk("hold_rst_score",     64'(score),     64'd0);
      chk("hold_rst_in_ready",  64'(in_ready),  64'd1);
      send_beat(X_W'($urandom), WV_W'($urandom), 1'b1, rand_bias());
      finish_frame(1'b0);
      release_result();

      // Large frame: 20 beats of 3*255*15 overflows the 16-bit instance.
      for (int i = 0; i < 20; i++) send_beat({3{8'd255}}, {3{5'd15}}, (i == 19), 24'd0);
      finish_frame(1'b0);
      chk("t20_score40", 64'($signed(score)), 64'd229500);
      release_result();

      // Random frames; some with res_ready already high before the result exists.
      for (int f = 0; f < 8; f++) begin
         len = $urandom_range(1, 6);
         res_ready = 1'($urandom);
         for (int i = 0; i < len; i++) begin
            send_beat(X_W'($urandom), WV_W'($urandom), (i == len - 1), rand_bias());
            if ((i < len - 1) && ($urandom_range(0, 1) == 1)) tick();
         end
         finish_frame(1'(f % 2));
         release_result();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
